sha1_round_ctrl: RTL and testbench

- Sequencing controller for the SHA-1 compression datapath. The datapath is built from synchronous-clear register slices for H0..H4, a..e and the 16-word W schedule.
- Accepts one 512-bit block per valid/ready handshake and walks the datapath through load, 80 rounds and the H update.
- Presents a digest-valid handshake after the last block of a message.
- Sits between the message padder (upstream) and the digest consumer (downstream). It owns no data, only control.

---
 rtl/sha1_pkg.sv | 24 ++
 rtl/sha1_round_dec.sv | 17 +
 rtl/sha1_round_ctrl.sv | 78 +++++++
 tb/tb_sha1_round_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// sha1_pkg: SHA-1 round constants, IV words, controller state and f_sel encodings shared with the datapath
package sha1_pkg;
  localparam logic [31:0] K0 = 32'h5A827999;
  localparam logic [31:0] K1 = 32'h6ED9EBA1;
  localparam logic [31:0] K2 = 32'h8F1BBCDC;
  localparam logic [31:0] K3 = 32'hCA62C1D6;
  localparam logic [31:0] H0 = 32'h67452301;
  localparam logic [31:0] H1 = 32'hEFCDAB89;
  localparam logic [31:0] H2 = 32'h98BADCFE;
  localparam logic [31:0] H3 = 32'h10325476;
  localparam logic [31:0] H4 = 32'hC3D2E1F0;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ROUND  = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_t;
  typedef enum logic [1:0] {
    CH  = 2'd0,
    PAR = 2'd1,
    MAJ = 2'd2
  } fsel_t;
endpackage

// File: rtl/sha1_round_dec.sv
// sha1_round_dec: round index t -> schedule select w_sel, boolean function select f_sel, round constant k
module sha1_round_dec import sha1_pkg::*; #(
  parameter int CW = 7
) (
  input  logic [CW-1:0] t,
  output logic          w_sel,
  output logic [1:0]    f_sel,
  output logic [31:0]   k
);
  logic [31:0] n;
  always_comb begin
    n = 32'(t);
    w_sel = n >= 32'd16;
    f_sel = n < 32'd20 ? CH : n < 32'd40 ? PAR : n < 32'd60 ? MAJ : PAR;
    k = n < 32'd20 ? K0 : n < 32'd40 ? K1 : n < 32'd60 ? K2 : K3;
  end
endmodule

// File: rtl/sha1_round_ctrl.sv
// sha1_round_ctrl: SHA-1 block sequencer (blk handshake in, load/round/update strobes and decodes out, digest handshake)
module sha1_round_ctrl import sha1_pkg::*; #(
  parameter int ROUNDS = 80,
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          r_n,
  input  logic          blk_valid,
  input  logic          blk_first,
  input  logic          blk_last,
  output logic          blk_ready,
  output logic          h_init,
  output logic          ld_blk,
  output logic          round_en,
  output logic [CW-1:0] t,
  output logic          w_sel,
  output logic [1:0]    f_sel,
  output logic [31:0]   k,
  output logic          h_upd,
  output logic          dig_valid,
  input  logic          dig_ready
);
  state_t state, state_nx;
  logic [CW-1:0] t_nx;
  logic first_q, last_q, first_nx, last_nx, armed, dw;
  logic [1:0] df;
  logic [31:0] dk;
  sha1_round_dec #(.CW(CW)) u_dec (.t(t), .w_sel(dw), .f_sel(df), .k(dk));
  always_ff @(posedge clk or negedge r_n)
    if (!r_n) begin
      state <= IDLE;
      t <= '0;
      first_q <= 1'b0;
      last_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      t <= t_nx;
      first_q <= first_nx;
      last_q <= last_nx;
      armed <= 1'b1;
    end
  always_comb begin
    state_nx = state;
    t_nx = t;
    first_nx = first_q;
    last_nx = last_q;
    case (state)
      IDLE: if (blk_valid && blk_ready) begin
        state_nx = LOAD;
        first_nx = blk_first;
        last_nx = blk_last;
      end
      LOAD: begin
        state_nx = ROUND;
        t_nx = '0;
      end
      ROUND: begin
        state_nx = t == CW'(ROUNDS - 1) ? UPDATE : ROUND;
        t_nx = t == CW'(ROUNDS - 1) ? '0 : t + 1'b1;
      end
      UPDATE: state_nx = last_q ? DONE : IDLE;
      DONE: state_nx = dig_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    blk_ready = state == IDLE && armed;
    h_init = state == LOAD && first_q;
    ld_blk = state == LOAD;
    round_en = state == ROUND;
    h_upd = state == UPDATE;
    dig_valid = state == DONE;
    w_sel = round_en && dw;
    f_sel = round_en ? df : 2'd0;
    k = round_en ? dk : 32'd0;
  end
endmodule

// File: tb/tb_sha1_round_ctrl.sv
// tb_sha1_round_ctrl: randomized scoreboard bench with a SHA-1 datapath model and reference compression function
module tb_sha1_round_ctrl;
  typedef logic [31:0] blk_t [16];
  localparam logic [159:0] IV = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0};
  localparam logic [31:0] KT [4] = '{32'h5A827999, 32'h6ED9EBA1, 32'h8F1BBCDC, 32'hCA62C1D6};
  logic clk = 1'b0;
  logic r_n, blk_valid, blk_first, blk_last, blk_ready, h_init, ld_blk, round_en;
  logic w_sel, h_upd, dig_valid, dig_ready;
  logic [6:0] t;
  logic [1:0] f_sel;
  logic [31:0] k;
  logic [47:0] act;
  int n_chk = 0, n_pass = 0;
  blk_t cur;
  logic [159:0] exp_q [$];
  logic [159:0] hreg;
  logic [31:0] ma, mb, mc, md, me, wt, tmp;
  logic [31:0] wm [16];
  logic dv_seen = 1'b0;
  always #5 clk = ~clk;
  sha1_round_ctrl #(.ROUNDS(80), .CW(7)) dut (
    .clk(clk), .r_n(r_n), .blk_valid(blk_valid), .blk_first(blk_first), .blk_last(blk_last),
    .blk_ready(blk_ready), .h_init(h_init), .ld_blk(ld_blk), .round_en(round_en), .t(t),
    .w_sel(w_sel), .f_sel(f_sel), .k(k), .h_upd(h_upd), .dig_valid(dig_valid), .dig_ready(dig_ready)
  );
  assign act = {blk_ready, h_init, ld_blk, round_en, h_upd, dig_valid, w_sel, f_sel, t, k};
  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction
  function automatic logic [31:0] fmix(input logic [1:0] s, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    return s == 2'd0 ? (b & c) | (~b & d) : s == 2'd2 ? (b & c) | (b & d) | (c & d) : b ^ c ^ d;
  endfunction
  function automatic logic [1:0] fs(input int g);
    return g == 0 ? 2'd0 : g == 2 ? 2'd2 : 2'd1;
  endfunction
  function automatic logic [159:0] compress(input logic [159:0] h, input blk_t b);
    logic [31:0] w [80];
    logic [31:0] a, bb, c, d, e, x;
    for (int i = 0; i < 80; i++)
      if (i < 16) w[i] = b[i];
      else w[i] = rol(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
    {a, bb, c, d, e} = h;
    for (int i = 0; i < 80; i++) begin
      x = rol(a, 5) + fmix(fs(i / 20), bb, c, d) + e + KT[i / 20] + w[i];
      e = d; d = c; c = rol(bb, 30); bb = a; a = x;
    end
    return {h[159:128] + a, h[127:96] + bb, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction
  function automatic logic [47:0] exp_vec(input int c, input logic f, input logic l);
    logic rnd;
    int tt;
    rnd = c >= 2 && c <= 81;
    tt = rnd ? c - 2 : 0;
    return {c == 83 && !l, c == 1 && f, c == 1, rnd, c == 82, c == 83 && l, tt >= 16,
            rnd ? fs(tt / 20) : 2'd0, 7'(tt), rnd ? KT[tt / 20] : 32'd0};
  endfunction
  task automatic chk(input string nm, input logic [159:0] a, input logic [159:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask
  always @(posedge clk) begin
    if (ld_blk) begin
      if (h_init) hreg <= IV;
      {ma, mb, mc, md, me} <= h_init ? IV : hreg;
      for (int i = 0; i < 16; i++) wm[i] <= cur[i];
    end
    if (round_en) begin
      wt = w_sel ? rol(wm[13] ^ wm[8] ^ wm[2] ^ wm[0], 1) : wm[0];
      tmp = rol(ma, 5) + fmix(f_sel, mb, mc, md) + me + k + wt;
      for (int i = 0; i < 15; i++) wm[i] <= wm[i+1];
      wm[15] <= wt;
      {ma, mb, mc, md, me} <= {tmp, ma, rol(mb, 30), mc, md};
    end
    if (h_upd) hreg <= {hreg[159:128] + ma, hreg[127:96] + mb, hreg[95:64] + mc, hreg[63:32] + md, hreg[31:0] + me};
  end
  always @(negedge clk) begin
    if (dig_valid && !dv_seen) begin
      if (exp_q.size() == 0) chk("digest_unexpected", {159'b0, dig_valid}, 160'd0);
      else chk("digest", hreg, exp_q.pop_front());
    end
    dv_seen = dig_valid;
  end
  task automatic send(input blk_t b, input logic f, input logic l, input int abort_c);
    int n;
    n = 0;
    cur = b; blk_first = f; blk_last = l; blk_valid = 1'b1;
    while (!blk_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk("accept_wait", {159'b0, blk_ready}, 160'd1);
    @(posedge clk); #1;
    for (int c = 1; c <= 83; c++) begin
      blk_valid = c < 82 ? 1'($urandom_range(0, 1)) : 1'b0;
      chk($sformatf("cycle%0d", c), act, exp_vec(c, f, l));
      if (c == abort_c) begin
        blk_valid = 1'b0;
        #2 r_n = 1'b0;
        #1 chk("reset_async", act, 0);
        #3 r_n = 1'b1;
        #1 chk("reset_release", act, 0);
        @(posedge clk); #1 chk("reset_ready", act, {1'b1, 47'b0});
        return;
      end
      if (c < 83) begin @(posedge clk); #1; end
    end
  endtask
  task automatic release_digest(input int hold, input logic vh);
    for (int i = 0; i < hold; i++) begin
      blk_valid = vh;
      @(posedge clk); #1;
      chk("digest_hold", act, {5'b0, 1'b1, 42'b0});
    end
    blk_valid = 1'b0; dig_ready = 1'b1;
    @(posedge clk); #1;
    dig_ready = 1'b0;
    chk("digest_taken", act, {1'b1, 47'b0});
  endtask
  initial begin
    blk_t abc, m1, m2, rb;
    logic [159:0] hv;
    int nb;
    abc = '{default: 32'h0}; abc[0] = 32'h61626380; abc[15] = 32'h18;
    m1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
           32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
           32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h0};
    m2 = '{default: 32'h0}; m2[15] = 32'h1C0;
    r_n = 1'b0; blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0; dig_ready = 1'b0;
    cur = abc;
    #2 chk("reset_hold", act, 0);
    #10 r_n = 1'b1;
    #1 chk("release_before_edge", act, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      chk("idle", act, {1'b1, 47'b0});
      @(posedge clk); #1;
    end
    exp_q.push_back(160'hA9993E364706816ABA3E25717850C26C9CD0D89D);
    send(abc, 1'b1, 1'b1, 0);
    release_digest(0, 1'b0);
    exp_q.push_back(160'h84983E441C3BD26EBAAE4AA1F95129E5E54670F1);
    send(m1, 1'b1, 1'b0, 0);
    send(m2, 1'b0, 1'b1, 0);
    release_digest(20, 1'b1);
    send(abc, 1'b1, 1'b1, 39);
    exp_q.push_back(160'hA9993E364706816ABA3E25717850C26C9CD0D89D);
    send(abc, 1'b1, 1'b1, 0);
    release_digest(2, 1'b0);
    for (int m = 0; m < 5; m++) begin
      nb = int'($urandom_range(1, 3));
      hv = IV;
      for (int bi = 0; bi < nb; bi++) begin
        for (int i = 0; i < 16; i++) rb[i] = $urandom();
        hv = compress(hv, rb);
        if (bi == nb - 1) exp_q.push_back(hv);
        send(rb, bi == 0, bi == nb - 1, 0);
      end
      release_digest(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end
    chk("queue_drained", 160'(exp_q.size()), 160'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
